// File: rtl/bus_pkg.sv
// Shared types and constants for the pad bus interface: FSM states, access
// size encodings, the reset value of the read-data register, and the
// alignment rule used to reject illegal accesses.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    READ_WAIT  = 2'd1,
    WRITE_WAIT = 2'd2,
    ERROR      = 2'd3
  } bus_state_e;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_RSVD = 2'b10;
  localparam logic [1:0] SIZE_WORD = 2'b11;

  // data_in resets to a NOP so the core fetches something harmless.
  localparam logic [31:0] NOP_INSN = 32'h00000013;

  // Halves need even addresses, words need 4-byte alignment, and the
  // reserved size code is always rejected.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = addr_lo[0];
      SIZE_WORD: bad = (addr_lo != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/pad_lane_align.sv
// Byte-lane steering between the CPU view (right-justified data) and the
// 32-bit memory view: write strobes, write-data replication and read-data
// extraction, all driven by access size and the low two address bits.
module pad_lane_align
  import bus_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] rdata_shifted;

  // Select lanes per size; the reserved size produces no strobes.
  always_comb begin
    rdata_shifted = rdata_i >> {addr_lo_i, 3'b000};
    wstrb_o       = 4'b0000;
    wdata_o       = store_data_i;
    rdata_o       = '0;
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o = 4'b0001 << addr_lo_i;
        wdata_o = {4{store_data_i[7:0]}};
        rdata_o = {24'h000000, rdata_shifted[7:0]};
      end
      SIZE_HALF: begin
        wstrb_o = 4'b0011 << addr_lo_i;
        wdata_o = {2{store_data_i[15:0]}};
        rdata_o = {16'h0000, rdata_shifted[15:0]};
      end
      SIZE_WORD: begin
        wstrb_o = 4'b1111;
        wdata_o = store_data_i;
        rdata_o = rdata_shifted;
      end
      default: begin
        wstrb_o = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/pad_bus_interface.sv
// Bridges the controller's pad strobes onto a req/ack memory port. One
// access is in flight at a time; the core is stalled until it completes,
// is rejected as misaligned, or times out waiting for mem_ack.
module pad_bus_interface
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [3:1]  phase,
  input  logic        pad_write_address,
  input  logic        pad_read,
  input  logic        pad_write,
  input  logic [1:0]  pad_data_size,
  input  logic [31:0] address_in,
  input  logic [31:0] store_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] data_in,
  output logic        stall,
  output logic        bus_error
);

  localparam int            CW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  bus_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   sdata_q, sdata_d;
  logic [31:0]   data_in_q, data_in_d;

  logic [31:0]   addr_eff;
  logic          misaligned;
  logic [3:0]    lane_wstrb;
  logic [31:0]   lane_rdata;

  // Strobes arrive already qualified by the phase sequencer, so the phase
  // vector itself carries no extra information here.
  logic unused_phase;
  assign unused_phase = ^phase;

  // An address strobe in the same cycle as the access strobe must be
  // checked against the address being latched, not the stale one.
  assign addr_eff   = pad_write_address ? address_in : addr_q;
  assign misaligned = is_misaligned(pad_data_size, addr_eff[1:0]);

  pad_lane_align u_lane_align (
    .size_i       (size_q),
    .addr_lo_i    (addr_q[1:0]),
    .store_data_i (sdata_q),
    .rdata_i      (mem_rdata),
    .wstrb_o      (lane_wstrb),
    .wdata_o      (mem_wdata),
    .rdata_o      (lane_rdata)
  );

  // State and datapath registers; reset aborts any access silently.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      size_q    <= SIZE_BYTE;
      sdata_q   <= '0;
      data_in_q <= NOP_INSN;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      sdata_q   <= sdata_d;
      data_in_q <= data_in_d;
    end
  end

  // Next-state logic: accept in IDLE (write wins over read), then wait
  // for ack or time out; ERROR is a one-cycle pulse.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    size_d    = size_q;
    sdata_d   = sdata_q;
    data_in_d = data_in_q;
    case (state_q)
      IDLE: begin
        if (pad_write_address) begin
          addr_d = address_in;
        end
        if (pad_write || pad_read) begin
          size_d  = pad_data_size;
          sdata_d = store_data;
          cnt_d   = '0;
          if (misaligned) begin
            state_d = ERROR;
          end else if (pad_write) begin
            state_d = WRITE_WAIT;
          end else begin
            state_d = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (mem_ack) begin
          data_in_d = lane_rdata;
          state_d   = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          data_in_d = '0;
          state_d   = ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE_WAIT: begin
        if (mem_ack) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ERROR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs decode directly from the state register so reset clears them
  // without waiting for a clock edge.
  assign mem_req   = (state_q == READ_WAIT) || (state_q == WRITE_WAIT);
  assign mem_we    = (state_q == WRITE_WAIT);
  assign mem_wstrb = (state_q == WRITE_WAIT) ? lane_wstrb : 4'b0000;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign stall     = (state_q != IDLE);
  assign bus_error = (state_q == ERROR);
  assign data_in   = data_in_q;

endmodule

// File: tb/tb_pad_bus_interface.sv
// Randomised transaction bench for pad_bus_interface with a behavioural
// model of alignment, lane steering, latency and timeout.
module tb_pad_bus_interface;

  localparam int          TIMEOUT = 16;
  localparam logic [31:0] NOP     = 32'h00000013;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [3:1]  phase;
  logic        pad_write_address, pad_read, pad_write;
  logic [1:0]  pad_data_size;
  logic [31:0] address_in, store_data, mem_rdata;
  logic        mem_ack;
  logic [31:0] mem_addr, mem_wdata, data_in;
  logic [3:0]  mem_wstrb;
  logic        mem_req, mem_we, stall, bus_error;

  int          tests_run    = 0;
  int          tests_failed = 0;
  int          txn_id       = 0;
  logic [31:0] model_data_in;

  pad_bus_interface #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .phase             (phase),
    .pad_write_address (pad_write_address),
    .pad_read          (pad_read),
    .pad_write         (pad_write),
    .pad_data_size     (pad_data_size),
    .address_in        (address_in),
    .store_data        (store_data),
    .mem_rdata         (mem_rdata),
    .mem_ack           (mem_ack),
    .mem_addr          (mem_addr),
    .mem_wdata         (mem_wdata),
    .mem_wstrb         (mem_wstrb),
    .mem_req           (mem_req),
    .mem_we            (mem_we),
    .data_in           (data_in),
    .stall             (stall),
    .bus_error         (bus_error)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_strobes();
    pad_write_address = 1'b0;
    pad_read          = 1'b0;
    pad_write         = 1'b0;
  endtask

  // Quiet cycles with stray acks, which must have no effect.
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      mem_ack   = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(negedge clock);
      mem_ack = 1'b0;
      check_val("idle_stall", 32'(stall), 32'd0);
      check_val("idle_req", 32'(mem_req), 32'd0);
      check_val("idle_data_in", data_in, model_data_in);
    end
  endtask

  // Address phase then access strobe; returns with the DUT just past acceptance.
  task automatic issue(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] sdata);
    address_in        = addr;
    pad_write_address = 1'b1;
    @(negedge clock);
    pad_write_address = 1'b0;
    address_in        = $urandom;
    check_val("addr_latch", mem_addr, addr & 32'hFFFF_FFFC);
    pad_data_size = size;
    store_data    = sdata;
    pad_write     = is_wr;
    pad_read      = !is_wr || also_rd;
    @(negedge clock);
    clear_strobes();
    store_data    = $urandom;
    pad_data_size = 2'($urandom_range(0, 3));
  endtask

  task automatic run_txn(input bit is_wr, input bit also_rd, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] sdata,
                         input logic [31:0] rdata, input int ack_at);
    int          lane;
    bit          mis;
    bit          done;
    int          stall_seen;
    int          stall_exp;
    logic [31:0] mask, exp_rd, exp_wd;
    logic [3:0]  exp_strb;
    string       outcome;

    lane = int'(addr % 4);
    mis  = (size == 2'b10) || (size == 2'b01 && (lane % 2) != 0) ||
           (size == 2'b11 && lane != 0);
    case (size)
      2'b00:   begin mask = 32'h0000_00FF; exp_strb = 4'(1 << lane); exp_wd = 32'(sdata[7:0]) * 32'h0101_0101; end
      2'b01:   begin mask = 32'h0000_FFFF; exp_strb = 4'(3 << lane); exp_wd = 32'(sdata[15:0]) * 32'h0001_0001; end
      default: begin mask = 32'hFFFF_FFFF; exp_strb = 4'hF;          exp_wd = sdata; end
    endcase
    exp_rd     = (rdata >> (8 * lane)) & mask;
    stall_seen = 0;
    done       = 1'b0;

    issue(is_wr, also_rd, addr, size, sdata);

    if (mis) begin
      stall_exp = 1;
      outcome   = "misaligned";
      if (stall) stall_seen++;
      check_val("mis_bus_error", 32'(bus_error), 32'd1);
      check_val("mis_req", 32'(mem_req), 32'd0);
      @(negedge clock);
    end else begin
      for (int k = 0; k < TIMEOUT; k++) begin
        if (stall) stall_seen++;
        check_val("wait_req", 32'(mem_req), 32'd1);
        check_val("wait_we", 32'(mem_we), 32'(is_wr));
        check_val("wait_bus_error", 32'(bus_error), 32'd0);
        check_val("wait_addr", mem_addr, addr & 32'hFFFF_FFFC);
        if (is_wr) begin
          check_val("wait_wstrb", 32'(mem_wstrb), 32'(exp_strb));
          check_val("wait_wdata", mem_wdata, exp_wd);
        end else begin
          check_val("wait_wstrb_rd", 32'(mem_wstrb), 32'd0);
        end
        if (k == ack_at) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata;
        end
        // Strobes while stalled must be ignored.
        pad_write_address = 1'($urandom_range(0, 1));
        pad_read          = 1'($urandom_range(0, 1));
        pad_write         = 1'($urandom_range(0, 1));
        address_in        = $urandom;
        @(negedge clock);
        clear_strobes();
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (k == ack_at) begin
          done = 1'b1;
          break;
        end
      end
      if (done) begin
        stall_exp = ack_at + 1;
        outcome   = "done";
        if (!is_wr) model_data_in = exp_rd;
      end else begin
        stall_exp = TIMEOUT + 1;
        outcome   = "timeout";
        if (stall) stall_seen++;
        check_val("tmo_bus_error", 32'(bus_error), 32'd1);
        check_val("tmo_req", 32'(mem_req), 32'd0);
        if (!is_wr) model_data_in = 32'd0;
        @(negedge clock);
      end
    end

    check_val("end_stall", 32'(stall), 32'd0);
    check_val("end_bus_error", 32'(bus_error), 32'd0);
    check_val("end_req", 32'(mem_req), 32'd0);
    check_val("end_data_in", data_in, model_data_in);
    check_val("stall_cycles", 32'(stall_seen), 32'(stall_exp));
    txn_id++;
    $display("[TB] txn %0d %s size=%0d addr=0x%08h ack_at=%0d -> %s data_in=0x%08h",
             txn_id, is_wr ? "WR" : "RD", size, addr, ack_at, outcome, data_in);
  endtask

  // Async reset in the middle of a write: mem_req must drop without a clock edge.
  task automatic reset_mid_write();
    issue(1'b1, 1'b0, 32'h0000_0300, 2'b11, 32'h1122_3344);
    check_val("rst_pre_req", 32'(mem_req), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("rst_req", 32'(mem_req), 32'd0);
    check_val("rst_we", 32'(mem_we), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_bus_error", 32'(bus_error), 32'd0);
    check_val("rst_wstrb", 32'(mem_wstrb), 32'd0);
    check_val("rst_data_in", data_in, NOP);
    check_val("rst_addr", mem_addr, 32'd0);
    model_data_in = NOP;
    @(negedge clock);
    reset_n = 1'b1;
    txn_id++;
    $display("[TB] txn %0d WR addr=0x00000300 -> reset during wait", txn_id);
  endtask

  initial begin
    reset_n       = 1'b0;
    phase         = 3'b001;
    clear_strobes();
    pad_data_size = 2'b00;
    address_in    = '0;
    store_data    = '0;
    mem_rdata     = '0;
    mem_ack       = 1'b0;
    model_data_in = NOP;

    @(negedge clock);
    @(negedge clock);
    check_val("reset_data_in", data_in, NOP);
    check_val("reset_req", 32'(mem_req), 32'd0);
    check_val("reset_we", 32'(mem_we), 32'd0);
    check_val("reset_wstrb", 32'(mem_wstrb), 32'd0);
    check_val("reset_stall", 32'(stall), 32'd0);
    check_val("reset_bus_error", 32'(bus_error), 32'd0);
    check_val("reset_addr", mem_addr, 32'd0);
    reset_n = 1'b1;
    idle_cycles(2);

    // Directed scenarios.
    run_txn(1'b0, 1'b0, 32'h0000_0100, 2'b11, 32'h0, 32'hDEAD_BEEF, 1);
    run_txn(1'b1, 1'b0, 32'h0000_0203, 2'b00, 32'h0000_00A5, 32'h0, 0);
    run_txn(1'b0, 1'b0, 32'h0000_0102, 2'b01, 32'h0, 32'h1234_ABCD, 0);
    run_txn(1'b0, 1'b0, 32'h0000_0101, 2'b11, 32'h0, 32'h0, 0);
    run_txn(1'b0, 1'b0, 32'h0000_0104, 2'b11, 32'h0, 32'h0, 99);
    run_txn(1'b1, 1'b1, 32'h0000_0402, 2'b01, 32'hCAFE_5A69, 32'h0, 3);
    run_txn(1'b1, 1'b0, 32'h0000_0500, 2'b10, 32'h1, 32'h0, 0);
    run_txn(1'b1, 1'b0, 32'h0000_0508, 2'b11, 32'h8765_4321, 32'h0, 15);
    idle_cycles(2);
    reset_mid_write();
    idle_cycles(2);

    // Randomised traffic.
    for (int t = 0; t < 250; t++) begin
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
              2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(0, 20));
      idle_cycles($urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
